fsoc_benchctl: RTL and testbench
================================

Name: fsoc_benchctl

Overview:
- Wishbone-slave peripheral in fsoc that firmware writes to in order to drive the 3-bit benchmark signalling lines.
- bench_o[0] is high while a benchmark runs, bench_o[1] signals PASS and bench_o[2] signals FAIL; these connect to the SoC GPO pins consumed by the simulation timing monitor.
- Keeps a hardware cycle counter of the run so firmware can read elapsed cycles without CSR support.

Parameters:
CNTW, 64, cycle-counter width (legal range 33..64); the upper bits read as 0 in CYC_HI when CNTW<64.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
wb_stb_i  in  1  Wishbone strobe (classic, no cyc)
wb_we_i  in  1  write enable
wb_adr_i  in  5  byte address; bits[4:2] select register
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte-lane selects
wb_dat_o  out  32  read data, valid while wb_ack_o=1
wb_ack_o  out  1  acknowledge
bench_o  out  3  [0] RUN level, [1] PASS level, [2] FAIL level
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset: state=IDLE, counter=0, shadow=0, err=0, bench_o=000, wb_ack_o=0, wb_dat_o=0. All outputs return to these values immediately on rst_i, without a clock edge, including mid-run.
- Handshake: ack_next = wb_stb_i & ~wb_ack_o, so ack is one cycle later and never on two consecutive cycles.
- Commit edge: the edge where wb_stb_i & ~wb_ack_o. A write takes effect on the commit edge. Read data is registered on the same edge.
- Register map:
  - 0x00 CTRL (W): bit0 START, bit1 STOP, bit2 PASS, bit3 FAIL, bit31 CLEAR. Bits[3:0] require wb_sel_i[0]; bit31 requires wb_sel_i[3].
  - 0x04 STATUS (R): [2:0]=bench_o, [5:3]=state (IDLE=0, RUN=1, DONE=2, PASS=3, FAIL=4), [6]=err.
  - 0x08 CYC_LO (R): counter[31:0]. Reading it loads shadow <= counter[CNTW-1:32] on the same edge.
  - 0x0C CYC_HI (R): shadow, giving an atomic 64-bit read as LO then HI.
  - Any other address reads 0. Writes to read-only registers or unmapped addresses are acked and ignored.
- CTRL bits with the same write: only the highest-priority set bit acts. Priority is CLEAR > FAIL > PASS > STOP > START.
- State transitions (bench_o is a pure decode of the state register):
  - IDLE(000): START -> RUN with counter<=0.
  - RUN(001): STOP -> DONE. START -> RUN with counter<=0 (restart).
  - DONE(000): PASS -> PASS(010), FAIL -> FAIL(100), START -> RUN with counter<=0.
  - PASS/FAIL are terminal; only CLEAR or reset leaves them.
  - CLEAR from any state -> IDLE with counter=0, shadow=0, err=0.
- Illegal commands set err (sticky) and leave the state unchanged:
  - PASS or FAIL in IDLE or RUN.
  - STOP in IDLE or DONE.
  - START in PASS or FAIL.
  - STOP in PASS or FAIL.
- Counter:
  - Increments on every edge where state==RUN, including the STOP commit edge, but not on the START commit edge (which writes 0).
  - START committed at edge e and STOP at edge e+N therefore gives counter=N.
  - Saturates at 2^CNTW-1 with no wrap.
  - Frozen in IDLE, DONE, PASS and FAIL.
  - Reads during RUN return the live value sampled at the commit edge.
- Timing: bench_o changes on the commit edge, so it is visible in the same cycle wb_ack_o is high.
- err_o is equal to STATUS[6].

Test Plan:
- Reset: assert rst_i mid-cycle -> bench_o=000 and err_o=0 immediately. After release, reads of 0x00..0x1C all return 0 and each ack lasts exactly 1 cycle.
- Timed run: write CTRL=0x1 with commit at edge e, idle, then write CTRL=0x2 with commit at e+100 -> bench_o[0] high exactly over [e, e+100). Reading CYC_LO returns 100, then CYC_HI returns 0.
- Verdict: after the timed run, write CTRL=0x4 -> bench_o=010 and STATUS=0x1A. A subsequent CTRL=0x1 leaves bench_o=010 and sets err_o=1.
- Illegal in RUN: START, then CTRL=0x8 -> bench_o stays 001, err_o=1 and the counter keeps incrementing. Then CTRL=0x80000000 with sel=1000 -> IDLE, err_o=0. The same write with sel=0001 is ignored.
- Priority: in IDLE, write CTRL=0x3 -> STOP wins, which is illegal in IDLE, so the state stays IDLE, err_o=1 and bench_o=000.
- Reset mid-run: START, 50 cycles, then pulse rst_i asynchronously -> bench_o=000 at once. After release, CYC_LO reads 0 and STATUS reads 0.

Source files
------------

// File: rtl/fsoc_benchctl.sv
// Wishbone-slave benchmark controller: drives RUN/PASS/FAIL signalling lines and
// keeps a saturating cycle counter of the run with an atomic LO/HI read path.
module fsoc_benchctl #(
   parameter int unsigned CNTW = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic [2:0]  bench_o,
   output logic        err_o
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRun  = 3'd1;
   localparam logic [2:0] StDone = 3'd2;
   localparam logic [2:0] StPass = 3'd3;
   localparam logic [2:0] StFail = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CNTW-33:0] shadow_q, shadow_d;
   logic            err_q, err_d;
   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic [31:0]     rdata;

   logic commit, wr_ctrl, rd;
   logic cmd_clear, cmd_fail, cmd_pass, cmd_stop, cmd_start;

   assign commit  = wb_stb_i & ~ack_q;
   assign wr_ctrl = commit & wb_we_i & (wb_adr_i[4:2] == 3'd0);
   assign rd      = commit & ~wb_we_i;

   // Only the highest-priority command bit of a write acts.
   assign cmd_clear = wr_ctrl & wb_sel_i[3] & wb_dat_i[31];
   assign cmd_fail  = wr_ctrl & wb_sel_i[0] & ~cmd_clear & wb_dat_i[3];
   assign cmd_pass  = wr_ctrl & wb_sel_i[0] & ~cmd_clear & ~wb_dat_i[3] & wb_dat_i[2];
   assign cmd_stop  = wr_ctrl & wb_sel_i[0] & ~cmd_clear & ~(|wb_dat_i[3:2]) & wb_dat_i[1];
   assign cmd_start = wr_ctrl & wb_sel_i[0] & ~cmd_clear & ~(|wb_dat_i[3:1]) & wb_dat_i[0];

   always_comb begin
      case (state_q)
         StRun:   bench_o = 3'b001;
         StPass:  bench_o = 3'b010;
         StFail:  bench_o = 3'b100;
         default: bench_o = 3'b000;
      endcase
   end

   always_comb begin
      case (wb_adr_i[4:2])
         3'd1:    rdata = {25'd0, err_q, state_q, bench_o};
         3'd2:    rdata = cnt_q[31:0];
         3'd3:    rdata = 32'(shadow_q);
         default: rdata = 32'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (state_q == StRun && !(&cnt_q)) begin
         cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
      if (rd && wb_adr_i[4:2] == 3'd2) begin
         shadow_d = cnt_q[CNTW-1:32];
      end
      if (cmd_clear) begin
         state_d  = StIdle;
         cnt_d    = '0;
         shadow_d = '0;
         err_d    = 1'b0;
      end else if (cmd_fail || cmd_pass) begin
         if (state_q == StDone) begin
            state_d = cmd_fail ? StFail : StPass;
         end else if (state_q == StIdle || state_q == StRun) begin
            err_d = 1'b1;
         end
      end else if (cmd_stop) begin
         if (state_q == StRun) begin
            state_d = StDone;
         end else begin
            err_d = 1'b1;
         end
      end else if (cmd_start) begin
         if (state_q == StPass || state_q == StFail) begin
            err_d = 1'b1;
         end else begin
            state_d = StRun;
            cnt_d   = '0;
         end
      end
   end

   assign ack_d = commit;
   assign dat_d = rd ? rdata : 32'd0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         shadow_q <= '0;
         err_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_fsoc_benchctl.sv
// Self-checking bench for fsoc_benchctl: directed scenarios plus randomized bus traffic
// compared against a run-window model of the benchmark controller.
module tb_fsoc_benchctl;

   logic        clk, rst;
   logic        stb, we;
   logic [4:0]  adr;
   logic [31:0] dat_i, dat_o;
   logic [3:0]  sel;
   logic        ack, err;
   logic [2:0]  bench;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   longint      edge_n   = 0;

   // Model: state as 0..4, run counter derived from the edge at which the run started.
   int          m_state;
   longint      m_start, m_frozen;
   logic [31:0] m_shadow;
   bit          m_err;

   fsoc_benchctl dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_sel_i (sel),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .bench_o  (bench),
      .err_o    (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint m_cnt(input longint k);
      return (m_state == 1) ? k - m_start : m_frozen;
   endfunction

   function automatic logic [2:0] m_bench();
      case (m_state)
         1:       return 3'b001;
         3:       return 3'b010;
         4:       return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic m_reset();
      m_state = 0; m_start = 0; m_frozen = 0; m_shadow = 0; m_err = 0;
   endtask

   // Apply one committed bus transaction at edge k; returns expected read data.
   task automatic m_xfer(input longint k, input bit w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] s, output logic [31:0] exp);
      longint c;
      c   = m_cnt(k - 1);
      exp = 32'd0;
      if (!w) begin
         case (a[4:2])
            3'd1: exp = {25'd0, m_err, 3'(m_state), m_bench()};
            3'd2: begin exp = c[31:0]; m_shadow = c[63:32]; end
            3'd3: exp = m_shadow;
            default: exp = 32'd0;
         endcase
      end else if (a[4:2] == 3'd0) begin
         if (d[31] && s[3]) begin
            m_state = 0; m_frozen = 0; m_shadow = 0; m_err = 0;
         end else if (s[0] && (d[3] || d[2])) begin
            if (m_state == 2) m_state = d[3] ? 4 : 3;
            else if (m_state <= 1) m_err = 1;
         end else if (s[0] && d[1]) begin
            if (m_state == 1) begin m_frozen = k - m_start; m_state = 2; end
            else m_err = 1;
         end else if (s[0] && d[0]) begin
            if (m_state >= 3) m_err = 1;
            else begin m_state = 1; m_start = k; end
         end
      end
   endtask

   task automatic xfer(input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] got);
      logic [31:0] exp;
      @(negedge clk);
      stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      m_xfer(edge_n + 1, w, a, d, s, exp);
      @(posedge clk); #1;
      check("ack_hi", ack, 1'b1);
      if (!w) check($sformatf("rdata@%0h", a), dat_o, exp);
      check("bench", bench, m_bench());
      check("err", err, m_err);
      got = dat_o;
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("ack_lo", ack, 1'b0);
   endtask

   task automatic wr(input logic [31:0] d, input logic [3:0] s);
      logic [31:0] g;
      xfer(1'b1, 5'h00, d, s, g);
   endtask

   task automatic rdr(input logic [4:0] a, output logic [31:0] g);
      xfer(1'b0, a, 32'd0, 4'hf, g);
   endtask

   initial begin
      logic [31:0] g;
      longint      e;
      int unsigned r;
      rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Post-reset reads of every register slot.
      for (int i = 0; i < 8; i++) begin
         rdr(5'(i * 4), g);
         check("rst_read", g, 32'd0);
      end

      // Priority: STOP beats START, illegal in IDLE.
      wr(32'h3, 4'h1);
      check("prio_err", err, 1'b1);

      // Async reset mid-run.
      wr(32'h1, 4'h1);
      repeat (50) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_bench", bench, 3'b000);
      check("arst_err", err, 1'b0);
      m_reset();
      @(negedge clk) rst = 1'b0;
      rdr(5'h08, g);
      check("arst_cyc", g, 32'd0);
      rdr(5'h04, g);
      check("arst_stat", g, 32'd0);

      // Timed run of exactly 100 edges.
      wr(32'h1, 4'h1);
      e = m_start;
      while (edge_n < e + 99) begin
         @(posedge clk); #1;
         check("run_level", bench[0], 1'b1);
      end
      wr(32'h2, 4'h1);
      check("stop_level", bench[0], 1'b0);
      rdr(5'h08, g);
      check("cyc_lo100", g, 32'd100);
      rdr(5'h0c, g);
      check("cyc_hi0", g, 32'd0);

      // Verdict, then illegal START in PASS.
      wr(32'h4, 4'h1);
      rdr(5'h04, g);
      check("stat_pass", g, 32'h1a);
      wr(32'h1, 4'h1);
      check("pass_hold", bench, 3'b010);
      check("pass_err", err, 1'b1);

      // Illegal FAIL while running; CLEAR needs sel[3].
      wr(32'h8000_0000, 4'h8);
      wr(32'h1, 4'h1);
      wr(32'h8, 4'h1);
      check("run_hold", bench, 3'b001);
      repeat (5) @(posedge clk);
      rdr(5'h08, g);
      wr(32'h8000_0000, 4'h1);
      check("clr_ignored", err, 1'b1);
      wr(32'h8000_0000, 4'h8);
      check("clr_err", err, 1'b0);
      check("clr_bench", bench, 3'b000);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5) begin
            logic [31:0] d;
            logic [3:0]  s;
            case ($urandom_range(0, 6))
               0: d = 32'h1;
               1: d = 32'h2;
               2: d = 32'h4;
               3: d = 32'h8;
               4: d = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h1;
               default: d = $urandom;
            endcase
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
            if ($urandom_range(0, 7) == 0) xfer(1'b1, 5'($urandom), d, s, g);
            else wr(d, s);
         end else begin
            rdr(5'($urandom), g);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
